// File: rtl/ctl.sv
// Start/pause/clear controller: three-state Moore FSM driven by edge-detected trig and split.
// Define CTL_SPLIT_WHILE_COUNTING_EN to let split clear the count while counting.
module ctl (
    input  logic clk,
    input  logic reset,
    input  logic trig,
    input  logic split,
    output logic init_regs,
    output logic count_enabled
);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StCounting = 2'b01,
        StPaused   = 2'b10,
        StUnused   = 2'b11
    } state_e;

    state_e state_q, state_d;
    logic   trig_q, split_q;
    logic   trig_ev, split_ev;

    assign trig_ev  = trig & ~trig_q;
    assign split_ev = split & ~split_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            trig_q  <= 1'b0;
            split_q <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig;
            split_q <= split;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (trig_ev) state_d = StCounting;
            end
            StCounting: begin
`ifdef CTL_SPLIT_WHILE_COUNTING_EN
                if (split_ev)     state_d = StIdle;
                else if (trig_ev) state_d = StPaused;
`else
                if (trig_ev) state_d = StPaused;
`endif
            end
            StPaused: begin
                // split wins over a coincident trig
                if (split_ev)     state_d = StIdle;
                else if (trig_ev) state_d = StCounting;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        init_regs     = 1'b0;
        count_enabled = 1'b0;
        case (state_q)
            StIdle:     init_regs = 1'b1;
            StCounting: count_enabled = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctl.sv
// Self-checking bench for ctl: vector table, corner-case sequences and randomized run
// against a rule-level model. Honours CTL_SPLIT_WHILE_COUNTING_EN.
module tb_ctl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic trig = 1'b0;
    logic split = 1'b0;
    logic init_regs, count_enabled;

    int checks = 0;
    int passed = 0;

    ctl dut (
        .clk           (clk),
        .reset         (reset),
        .trig          (trig),
        .split         (split),
        .init_regs     (init_regs),
        .count_enabled (count_enabled)
    );

    always #5 clk = ~clk;

`ifdef CTL_SPLIT_WHILE_COUNTING_EN
    localparam bit SplitInCount = 1'b1;
`else
    localparam bit SplitInCount = 1'b0;
`endif

    // Model: mode is "idle", "counting" or "paused"; events from previous sampled levels.
    string m_mode;
    bit    m_prev_t, m_prev_s;

    task automatic model_reset();
        m_mode   = "idle";
        m_prev_t = 1'b0;
        m_prev_s = 1'b0;
    endtask

    task automatic model_clock(input bit t, input bit s);
        bit tev, sev;
        tev = t && !m_prev_t;
        sev = s && !m_prev_s;
        m_prev_t = t;
        m_prev_s = s;
        if (m_mode == "idle") begin
            if (tev) m_mode = "counting";
        end else if (m_mode == "counting") begin
            if (SplitInCount && sev) m_mode = "idle";
            else if (tev)            m_mode = "paused";
        end else begin
            if (sev)      m_mode = "idle";
            else if (tev) m_mode = "counting";
        end
    endtask

    task automatic check(input string name, input logic exp_i, input logic exp_c);
        checks++;
        if (init_regs === exp_i && count_enabled === exp_c) begin
            passed++;
        end else begin
            $display("FAIL %s: got init_regs=%b count_enabled=%b, want init_regs=%b count_enabled=%b",
                     name, init_regs, count_enabled, exp_i, exp_c);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_mode == "idle", m_mode == "counting");
    endtask

    task automatic step(input logic t, input logic s, input string name,
                        input logic exp_i, input logic exp_c);
        trig  = t;
        split = s;
        @(posedge clk);
        #1;
        check(name, exp_i, exp_c);
    endtask

    task automatic do_reset();
        trig  = 1'b0;
        split = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_async", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 1'b1, 1'b0);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic  t;
        logic  s;
        logic  exp_i;
        logic  exp_c;
        string name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, "idle_after_reset"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, "trig_to_counting"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, "counting_hold"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "trig_to_paused"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, "paused_hold"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "split_to_idle"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "split_held_idle"});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, "idle_hold"});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, "split_in_idle"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, "held_trig_1"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, "held_trig_2"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, "held_trig_3"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, "held_trig_4"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, "held_trig_5"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, "release_trig"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, "pause_again"});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, "paused_hold2"});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, "resume_counting"});

        do_reset();
        foreach (vecs[i]) step(vecs[i].t, vecs[i].s, vecs[i].name, vecs[i].exp_i, vecs[i].exp_c);

        // split while counting depends on build option
        do_reset();
        step(1'b1, 1'b0, "sc_count", 1'b0, 1'b1);
        step(1'b0, 1'b1, "split_in_counting", SplitInCount, !SplitInCount);

        // trig and split together in PAUSED
        do_reset();
        step(1'b1, 1'b0, "ts_count", 1'b0, 1'b1);
        step(1'b0, 1'b0, "ts_count_hold", 1'b0, 1'b1);
        step(1'b1, 1'b0, "ts_pause", 1'b0, 1'b0);
        step(1'b0, 1'b0, "ts_pause_hold", 1'b0, 1'b0);
        step(1'b1, 1'b1, "trig_split_paused", 1'b1, 1'b0);

        // reset mid-count acts before the next edge
        do_reset();
        step(1'b1, 1'b0, "mid_count", 1'b0, 1'b1);
        trig  = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_mid_count_async", 1'b1, 1'b0);
        // trig high across release counts as an event at the first edge
        trig = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_count_held", 1'b1, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("trig_at_release", 1'b0, 1'b1);
        step(1'b1, 1'b0, "trig_still_held", 1'b0, 1'b1);

        // randomized run against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bit t, s;
            t = ($urandom_range(0, 2) == 0);
            s = ($urandom_range(0, 3) == 0);
            trig  = t;
            split = s;
            @(posedge clk);
            model_clock(t, s);
            #1;
            check_model("random");
            if (n % 97 == 96) begin
                reset = 1'b1;
                #1;
                model_reset();
                check_model("random_reset");
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
